// File: rtl/param_updown_counter.sv
// param_updown_counter: parameterised up/down counter with a step input.
// Boundary behaviour is selected by WRAP_MODE: 1 = wrap modulo (MAX_VAL+1), 0 = saturate.
// Priority on each rising edge: clear > load > count > hold.
// ovf_pulse/unf_pulse are registered one-cycle flags for boundary crossings.
// Optional feature macro: UDC_STICKY_STATUS_EN. When it is defined, ovf_sticky/unf_sticky
// latch the boundary events until status_clr. When it is not defined, both flags stay 0
// and status_clr has no effect.
module param_updown_counter #(
  parameter int BITSIZE   = 4,
  parameter int MAX_VAL   = 2**BITSIZE-1,
  parameter int WRAP_MODE = 1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear,
  input  logic               load,
  input  logic [BITSIZE-1:0] load_val,
  input  logic               up,
  input  logic               down,
  input  logic [BITSIZE-1:0] step,
  input  logic               status_clr,
  output logic [BITSIZE-1:0] count_out,
  output logic               at_max,
  output logic               at_min,
  output logic               ovf_pulse,
  output logic               unf_pulse,
  output logic               ovf_sticky,
  output logic               unf_sticky
);

  // Arithmetic is done one bit wider than the count so sums never truncate.
  localparam logic [BITSIZE:0]   MAX_W   = (BITSIZE+1)'(MAX_VAL);
  localparam logic [BITSIZE:0]   RANGE_W = (BITSIZE+1)'(MAX_VAL + 1);
  localparam logic [BITSIZE-1:0] MAX_N   = BITSIZE'(MAX_VAL);

  logic [BITSIZE-1:0] count_q;
  logic [BITSIZE-1:0] count_nxt;
  logic               ovf_q;
  logic               unf_q;
  logic               ovf_nxt;
  logic               unf_nxt;
  logic [BITSIZE:0]   cnt_ext;
  logic [BITSIZE:0]   step_eff;
  logic [BITSIZE:0]   sum_up;
  logic [BITSIZE:0]   sum_wrap_dn;
  logic               do_up;
  logic               do_down;

  // Next-state computation: clear, clamped load, stepped count with wrap/saturate.
  always_comb begin
    cnt_ext     = {1'b0, count_q};
    step_eff    = ({1'b0, step} > MAX_W) ? MAX_W : {1'b0, step};
    sum_up      = cnt_ext + step_eff;
    sum_wrap_dn = cnt_ext + RANGE_W - step_eff;
    do_up       = up & ~down & (step_eff != '0);
    do_down     = down & ~up & (step_eff != '0);
    count_nxt   = count_q;
    ovf_nxt     = 1'b0;
    unf_nxt     = 1'b0;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = ({1'b0, load_val} > MAX_W) ? MAX_N : load_val;
    end else if (do_up) begin
      if (sum_up > MAX_W) begin
        ovf_nxt   = 1'b1;
        count_nxt = (WRAP_MODE != 0) ? BITSIZE'(sum_up - RANGE_W) : MAX_N;
      end else begin
        count_nxt = sum_up[BITSIZE-1:0];
      end
    end else if (do_down) begin
      if (cnt_ext >= step_eff) begin
        count_nxt = BITSIZE'(cnt_ext - step_eff);
      end else begin
        unf_nxt   = 1'b1;
        count_nxt = (WRAP_MODE != 0) ? BITSIZE'(sum_wrap_dn) : '0;
      end
    end
  end

  // Count and boundary-pulse registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  assign count_out = count_q;
  assign at_max    = (count_q == MAX_N);
  assign at_min    = (count_q == '0);
  assign ovf_pulse = ovf_q;
  assign unf_pulse = unf_q;

`ifdef UDC_STICKY_STATUS_EN
  logic ovf_sticky_q;
  logic unf_sticky_q;

  // Sticky flags set together with their pulse; a new event wins over status_clr.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_nxt | (ovf_sticky_q & ~status_clr);
      unf_sticky_q <= unf_nxt | (unf_sticky_q & ~status_clr);
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign unf_sticky = unf_sticky_q;
`else
  logic status_clr_unused;

  assign status_clr_unused = status_clr;
  assign ovf_sticky        = 1'b0;
  assign unf_sticky        = 1'b0;
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: drives two counters (wrapping and saturating, BITSIZE=4,
// MAX_VAL=9) with the same inputs. It checks a directed vector table, sticky and reset
// sequences, and randomized cycles against an integer reference model.
module tb_param_updown_counter;
  localparam int W    = 4;
  localparam int MAXV = 9;
`ifdef UDC_STICKY_STATUS_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         up = 1'b0;
  logic         down = 1'b0;
  logic [W-1:0] step = '0;
  logic         status_clr = 1'b0;

  logic [W-1:0] cnt_w, cnt_s;
  logic amax_w, amin_w, ovf_w, unf_w, osk_w, usk_w;
  logic amax_s, amin_s, ovf_s, unf_s, osk_s, usk_s;

  param_updown_counter #(.BITSIZE(W), .MAX_VAL(MAXV), .WRAP_MODE(1)) dut_w (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .load_val(load_val),
    .up(up), .down(down), .step(step), .status_clr(status_clr),
    .count_out(cnt_w), .at_max(amax_w), .at_min(amin_w), .ovf_pulse(ovf_w),
    .unf_pulse(unf_w), .ovf_sticky(osk_w), .unf_sticky(usk_w));

  param_updown_counter #(.BITSIZE(W), .MAX_VAL(MAXV), .WRAP_MODE(0)) dut_s (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .load_val(load_val),
    .up(up), .down(down), .step(step), .status_clr(status_clr),
    .count_out(cnt_s), .at_max(amax_s), .at_min(amin_s), .ovf_pulse(ovf_s),
    .unf_pulse(unf_s), .ovf_sticky(osk_s), .unf_sticky(usk_s));

  // Clock generation
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Expected sticky state, kept by the bench
  bit sow = 0, suw = 0, sos = 0, sus = 0;

  // Scoreboard queues: {count, ovf, unf} per DUT
  logic [W+1:0] exp_qw[$];
  logic [W+1:0] exp_qs[$];

  typedef struct {
    bit clr; bit ld; int lv; bit u; bit d; int st;
    int cw; int ow; int uw; int cs; int os; int us;
  } vec_t;
  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_outputs(input string tag, input int cw, input int ow, input int uw,
                               input int cs, input int os, input int us);
    check({tag, " count_w"}, int'(cnt_w), cw);
    check({tag, " at_max_w"}, int'(amax_w), int'(cw == MAXV));
    check({tag, " at_min_w"}, int'(amin_w), int'(cw == 0));
    check({tag, " ovf_w"}, int'(ovf_w), ow);
    check({tag, " unf_w"}, int'(unf_w), uw);
    check({tag, " ovf_sticky_w"}, int'(osk_w), int'(sow));
    check({tag, " unf_sticky_w"}, int'(usk_w), int'(suw));
    check({tag, " count_s"}, int'(cnt_s), cs);
    check({tag, " at_max_s"}, int'(amax_s), int'(cs == MAXV));
    check({tag, " at_min_s"}, int'(amin_s), int'(cs == 0));
    check({tag, " ovf_s"}, int'(ovf_s), os);
    check({tag, " unf_s"}, int'(unf_s), us);
    check({tag, " ovf_sticky_s"}, int'(osk_s), int'(sos));
    check({tag, " unf_sticky_s"}, int'(usk_s), int'(sus));
  endtask

  // Sticky expectation after an edge, using the status_clr that edge saw
  task automatic update_sticky(input int ow, input int uw, input int os, input int us);
    if (STK) begin
      sow = (ow != 0) || (sow && !status_clr);
      suw = (uw != 0) || (suw && !status_clr);
      sos = (os != 0) || (sos && !status_clr);
      sus = (us != 0) || (sus && !status_clr);
    end
  endtask

  // Reference model: one edge of the counter computed from the counting rules
  task automatic model(input int c, input bit wrap, output int nc, output int o, output int u);
    int s;
    s  = (int'(step) > MAXV) ? MAXV : int'(step);
    nc = c; o = 0; u = 0;
    if (clear) nc = 0;
    else if (load) nc = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
    else if (up && !down && s > 0) begin
      if (c + s <= MAXV) nc = c + s;
      else begin o = 1; nc = wrap ? c + s - (MAXV + 1) : MAXV; end
    end else if (down && !up && s > 0) begin
      if (c >= s) nc = c - s;
      else begin u = 1; nc = wrap ? c + (MAXV + 1) - s : 0; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit l, input int lv, input bit u, input bit d,
                       input int st, input bit sc);
    clear = c; load = l; load_val = W'(lv); up = u; down = d; step = W'(st); status_clr = sc;
  endtask

  initial begin
    int m_cw, m_cs, ow, uw, os, us;
    logic [W+1:0] ew, es;

    //            clr ld lv up dn st | cw ow uw | cs os us
    vecs[0]  = '{0, 0,  0, 1, 0, 1,   1, 0, 0,   1, 0, 0};
    vecs[1]  = '{0, 0,  0, 1, 0, 1,   2, 0, 0,   2, 0, 0};
    vecs[2]  = '{0, 0,  0, 1, 0, 1,   3, 0, 0,   3, 0, 0};
    vecs[3]  = '{0, 0,  0, 1, 1, 1,   3, 0, 0,   3, 0, 0};
    vecs[4]  = '{0, 0,  0, 0, 1, 1,   2, 0, 0,   2, 0, 0};
    vecs[5]  = '{0, 0,  0, 0, 1, 1,   1, 0, 0,   1, 0, 0};
    vecs[6]  = '{0, 0,  0, 0, 1, 1,   0, 0, 0,   0, 0, 0};
    vecs[7]  = '{0, 1,  8, 0, 0, 0,   8, 0, 0,   8, 0, 0};
    vecs[8]  = '{0, 0,  0, 1, 0, 3,   1, 1, 0,   9, 1, 0};
    vecs[9]  = '{0, 0,  0, 1, 0, 3,   4, 0, 0,   9, 1, 0};
    vecs[10] = '{0, 0,  0, 0, 1, 4,   0, 0, 0,   5, 0, 0};
    vecs[11] = '{0, 0,  0, 0, 1, 4,   6, 0, 1,   1, 0, 0};
    vecs[12] = '{0, 0,  0, 0, 1, 15,  7, 0, 1,   0, 0, 1};
    vecs[13] = '{1, 1, 12, 1, 0, 1,   0, 0, 0,   0, 0, 0};
    vecs[14] = '{0, 1, 12, 1, 0, 1,   9, 0, 0,   9, 0, 0};
    vecs[15] = '{0, 0,  0, 1, 0, 0,   9, 0, 0,   9, 0, 0};
    vecs[16] = '{0, 0,  0, 0, 1, 0,   9, 0, 0,   9, 0, 0};
    vecs[17] = '{0, 0,  0, 1, 0, 9,   8, 1, 0,   9, 1, 0};

    // Reset state
    #1;
    check_outputs("reset", 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // Directed vector table; the first count lands on the first edge after reset release
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].u, vecs[i].d, vecs[i].st, 1'b0);
      tick();
      update_sticky(vecs[i].ow, vecs[i].uw, vecs[i].os, vecs[i].us);
      check_outputs($sformatf("vec%0d", i), vecs[i].cw, vecs[i].ow, vecs[i].uw,
                    vecs[i].cs, vecs[i].os, vecs[i].us);
    end

    // Sticky sequence: overflow, five idle cycles, then status_clr
    drive(0, 1, 9, 0, 0, 0, 0);
    tick(); update_sticky(0, 0, 0, 0); check_outputs("stk_load", 9, 0, 0, 9, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    tick(); update_sticky(1, 0, 1, 0); check_outputs("stk_ovf", 0, 1, 0, 9, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); update_sticky(0, 0, 0, 0);
      check_outputs($sformatf("stk_idle%0d", i), 0, 0, 0, 9, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick(); update_sticky(0, 0, 0, 0); check_outputs("stk_clr", 0, 0, 0, 9, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); update_sticky(0, 0, 0, 0); check_outputs("stk_after", 0, 0, 0, 9, 0, 0);

    // Randomized cycles against the reference model
    m_cw = 0; m_cs = 9;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 15),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 15),
            $urandom_range(0, 7) == 0);
      model(m_cw, 1'b1, m_cw, ow, uw);
      model(m_cs, 1'b0, m_cs, os, us);
      exp_qw.push_back({W'(m_cw), ow[0], uw[0]});
      exp_qs.push_back({W'(m_cs), os[0], us[0]});
      tick();
      update_sticky(ow, uw, os, us);
      ew = exp_qw.pop_front();
      es = exp_qs.pop_front();
      check_outputs($sformatf("rnd%0d", n), int'(ew[W+1:2]), int'(ew[1]), int'(ew[0]),
                    int'(es[W+1:2]), int'(es[1]), int'(es[0]));
    end

    // Asynchronous reset mid-clock with count at 5 and a pulse in flight
    drive(0, 1, 8, 0, 0, 0, 0);
    tick(); update_sticky(0, 0, 0, 0); check_outputs("pre_rst_load", 8, 0, 0, 8, 0, 0);
    drive(0, 0, 0, 1, 0, 7, 0);
    tick(); update_sticky(1, 0, 1, 0); check_outputs("pre_rst_up", 5, 1, 0, 9, 1, 0);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    sow = 0; suw = 0; sos = 0; sus = 0;
    check_outputs("async_rst", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    tick(); check_outputs("rst_held", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_rst = 1'b1;
    tick(); update_sticky(0, 0, 0, 0); check_outputs("post_rst", 1, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
